// File: rtl/multi_evt_counter.sv
// multi_evt_counter: NUM_CH independent modulo-MAX_COUNT event counters with
// per-channel direction, level/edge qualification, wrap pulses and sticky wrap
// flags. A snapshot register captures all counts and sticky flags atomically
// and holds them behind a valid/ready handshake.
module multi_evt_counter #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned MAX_COUNT = 40_000,
  localparam int unsigned CW       = $clog2(MAX_COUNT)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 clear_in,
  input  logic                 edge_mode_in,
  input  logic [NUM_CH-1:0]    evt_in,
  input  logic [NUM_CH-1:0]    dir_in,
  output logic [NUM_CH*CW-1:0] count_out,
  output logic [NUM_CH-1:0]    wrap_out,
  input  logic                 snap_in,
  output logic                 snap_valid_out,
  input  logic                 snap_ready_in,
  output logic [NUM_CH*CW-1:0] snap_data_out,
  output logic [NUM_CH-1:0]    snap_wrap_out,
  output logic                 snap_drop_out
);

  localparam logic [CW-1:0] TOP = CW'(MAX_COUNT - 1);

  logic [NUM_CH-1:0] sticky;
  logic              capture;

  // A capture happens when the holding register is empty or being drained
  assign capture = snap_in && (!snap_valid_out || snap_ready_in);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap_q;
    logic          wrap_d;
    logic          prev_q;
    logic          sticky_q;
    logic          qual;

    // Qualified event: level, or rising edge against last cycle's input
    assign qual = edge_mode_in ? (evt_in[g] & ~prev_q) : evt_in[g];

    // Next count and wrap pulse; clear overrides any event this cycle
    always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (clear_in) begin
        cnt_d = '0;
      end else if (qual) begin
        if (dir_in[g]) begin
          if (cnt_q == TOP) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          if (cnt_q == '0) begin
            cnt_d  = TOP;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
    end

    // Channel state; a wrap seen in a capture cycle opens the next window
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        cnt_q    <= '0;
        wrap_q   <= 1'b0;
        prev_q   <= 1'b0;
        sticky_q <= 1'b0;
      end else begin
        prev_q <= evt_in[g];
        cnt_q  <= cnt_d;
        wrap_q <= wrap_d;
        if (clear_in) begin
          sticky_q <= 1'b0;
        end else if (capture) begin
          sticky_q <= wrap_q;
        end else if (wrap_q) begin
          sticky_q <= 1'b1;
        end
      end
    end

    assign count_out[g*CW +: CW] = cnt_q;
    assign wrap_out[g]           = wrap_q;
    assign sticky[g]             = sticky_q;
  end

  // Snapshot holding register with valid/ready handshake and drop pulse
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      snap_valid_out <= 1'b0;
      snap_data_out  <= '0;
      snap_wrap_out  <= '0;
      snap_drop_out  <= 1'b0;
    end else begin
      snap_drop_out <= snap_in && snap_valid_out && !snap_ready_in;
      if (capture) begin
        snap_valid_out <= 1'b1;
        snap_data_out  <= count_out;
        snap_wrap_out  <= sticky;
      end else if (snap_valid_out && snap_ready_in) begin
        snap_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multi_evt_counter.sv
// Testbench for multi_evt_counter: directed table and sequences plus random
// stimulus compared each cycle against a behavioural model.
module tb_multi_evt_counter;
  localparam int unsigned NCH = 4;
  localparam int unsigned MC  = 5;
  localparam int unsigned CW  = $clog2(MC);
  localparam int          MI  = 5;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              clear_in;
  logic              edge_mode_in;
  logic [NCH-1:0]    evt_in;
  logic [NCH-1:0]    dir_in;
  logic [NCH*CW-1:0] count_out;
  logic [NCH-1:0]    wrap_out;
  logic              snap_in;
  logic              snap_valid_out;
  logic              snap_ready_in;
  logic [NCH*CW-1:0] snap_data_out;
  logic [NCH-1:0]    snap_wrap_out;
  logic              snap_drop_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int           m_cnt   [NCH];
  int           m_sdata [NCH];
  bit [NCH-1:0] m_wrap, m_prev, m_sticky, m_swrap;
  bit           m_valid, m_drop;

  typedef struct {
    logic [NCH-1:0] evt;
    logic [NCH-1:0] dir;
    int             exp_c0;
    logic           exp_w0;
  } vec_t;

  vec_t tbl [7];

  multi_evt_counter #(.NUM_CH(NCH), .MAX_COUNT(MC)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .clear_in       (clear_in),
    .edge_mode_in   (edge_mode_in),
    .evt_in         (evt_in),
    .dir_in         (dir_in),
    .count_out      (count_out),
    .wrap_out       (wrap_out),
    .snap_in        (snap_in),
    .snap_valid_out (snap_valid_out),
    .snap_ready_in  (snap_ready_in),
    .snap_data_out  (snap_data_out),
    .snap_wrap_out  (snap_wrap_out),
    .snap_drop_out  (snap_drop_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [NCH*CW-1:0] packc(input int c0, input int c1, input int c2, input int c3);
    logic [NCH*CW-1:0] r;
    r = '0;
    r[0*CW +: CW] = CW'(c0);
    r[1*CW +: CW] = CW'(c1);
    r[2*CW +: CW] = CW'(c2);
    r[3*CW +: CW] = CW'(c3);
    return r;
  endfunction

  function automatic logic [NCH*CW-1:0] pack_arr(input int a [NCH]);
    logic [NCH*CW-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[i*CW +: CW] = CW'(a[i]);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    check("count_out", 64'(count_out), 64'(pack_arr(m_cnt)));
    check("wrap_out", 64'(wrap_out), 64'(m_wrap));
    check("snap_valid_out", 64'(snap_valid_out), 64'(m_valid));
    check("snap_data_out", 64'(snap_data_out), 64'(pack_arr(m_sdata)));
    check("snap_wrap_out", 64'(snap_wrap_out), 64'(m_swrap));
    check("snap_drop_out", 64'(snap_drop_out), 64'(m_drop));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i]   = 0;
      m_sdata[i] = 0;
    end
    m_wrap = '0; m_prev = '0; m_sticky = '0; m_swrap = '0;
    m_valid = 1'b0; m_drop = 1'b0;
  endtask

  // Advance one clock, update the model from the rules, compare everything
  task automatic tick();
    int           n_cnt [NCH];
    bit [NCH-1:0] q, n_wrap, n_sticky;
    bit           cap, n_valid, n_drop;
    q   = edge_mode_in ? (evt_in & ~m_prev) : evt_in;
    cap = snap_in && (!m_valid || snap_ready_in);
    for (int i = 0; i < NCH; i++) begin
      n_cnt[i]  = m_cnt[i];
      n_wrap[i] = 1'b0;
      if (clear_in) begin
        n_cnt[i] = 0;
      end else if (q[i]) begin
        if (dir_in[i]) begin
          n_cnt[i]  = (m_cnt[i] + 1) % MI;
          n_wrap[i] = (m_cnt[i] == MI - 1);
        end else begin
          n_cnt[i]  = (m_cnt[i] + MI - 1) % MI;
          n_wrap[i] = (m_cnt[i] == 0);
        end
      end
    end
    n_sticky = clear_in ? '0 : (cap ? m_wrap : (m_sticky | m_wrap));
    n_drop   = snap_in && m_valid && !snap_ready_in;
    n_valid  = cap ? 1'b1 : ((m_valid && snap_ready_in) ? 1'b0 : m_valid);
    if (cap) begin
      m_sdata = m_cnt;
      m_swrap = m_sticky;
    end
    @(posedge clk_in);
    #1;
    m_cnt    = n_cnt;
    m_wrap   = n_wrap;
    m_sticky = n_sticky;
    m_valid  = n_valid;
    m_drop   = n_drop;
    m_prev   = evt_in;
    check_all();
  endtask

  initial begin
    tbl[0] = '{evt: 4'b0001, dir: 4'b0001, exp_c0: 1, exp_w0: 1'b0};
    tbl[1] = '{evt: 4'b0001, dir: 4'b0001, exp_c0: 2, exp_w0: 1'b0};
    tbl[2] = '{evt: 4'b0001, dir: 4'b0001, exp_c0: 3, exp_w0: 1'b0};
    tbl[3] = '{evt: 4'b0001, dir: 4'b0001, exp_c0: 4, exp_w0: 1'b0};
    tbl[4] = '{evt: 4'b0001, dir: 4'b0001, exp_c0: 0, exp_w0: 1'b1};
    tbl[5] = '{evt: 4'b0001, dir: 4'b0001, exp_c0: 1, exp_w0: 1'b0};
    tbl[6] = '{evt: 4'b0001, dir: 4'b0001, exp_c0: 2, exp_w0: 1'b0};

    rst_n_in = 1'b0; clear_in = 1'b0; edge_mode_in = 1'b0;
    evt_in = '0; dir_in = '0; snap_in = 1'b0; snap_ready_in = 1'b0;
    model_reset();
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    check("reset_count", 64'(count_out), 64'(0));
    check("reset_snap", 64'({snap_valid_out, snap_drop_out, snap_wrap_out, snap_data_out, wrap_out}), 64'(0));
    #2;
    rst_n_in = 1'b1;

    // Level-mode up count through a wrap on ch0
    for (int k = 0; k < 7; k++) begin
      evt_in = tbl[k].evt;
      dir_in = tbl[k].dir;
      tick();
      check("tbl_count0", 64'(count_out[CW-1:0]), 64'(tbl[k].exp_c0));
      check("tbl_wrap0", 64'(wrap_out[0]), 64'(tbl[k].exp_w0));
    end

    // Down wrap on ch1, sticky into the next snapshot only
    evt_in = 4'b0010; dir_in = 4'b0000;
    tick();
    check("down_count1", 64'(count_out[CW +: CW]), 64'(4));
    check("down_wrap1", 64'(wrap_out[1]), 64'(1));
    evt_in = '0;
    tick();
    snap_in = 1'b1;
    tick();
    check("sticky_snap1", 64'(snap_wrap_out[1]), 64'(1));
    snap_in = 1'b0; snap_ready_in = 1'b1;
    tick();
    snap_ready_in = 1'b0; snap_in = 1'b1;
    tick();
    check("sticky_snap2", 64'(snap_wrap_out[1]), 64'(0));
    snap_in = 1'b0; snap_ready_in = 1'b1;
    tick();
    snap_ready_in = 1'b0;

    // Edge mode: ch2 held high counts once per rising edge
    edge_mode_in = 1'b1; dir_in = 4'b0100; evt_in = 4'b0100;
    for (int k = 0; k < 10; k++) tick();
    evt_in = '0;
    tick();
    evt_in = 4'b0100;
    for (int k = 0; k < 3; k++) tick();
    check("edge_count2", 64'(count_out[2*CW +: CW]), 64'(2));
    evt_in = '0; edge_mode_in = 1'b0;
    tick();

    // Held snapshot, dropped second request, then drain
    snap_in = 1'b1;
    tick();
    snap_in = 1'b0;
    tick();
    snap_in = 1'b1;
    tick();
    check("drop_pulse", 64'(snap_drop_out), 64'(1));
    check("held_data", 64'(snap_data_out), 64'(packc(2, 4, 2, 0)));
    check("held_valid", 64'(snap_valid_out), 64'(1));
    snap_in = 1'b0;
    tick();
    check("drop_once", 64'(snap_drop_out), 64'(0));
    snap_ready_in = 1'b1;
    tick();
    check("drain_valid", 64'(snap_valid_out), 64'(0));
    snap_ready_in = 1'b0;

    // Capture, clear and event together: pre-clear values captured
    evt_in = 4'b0001; dir_in = 4'b0001;
    tick();
    snap_in = 1'b1; clear_in = 1'b1;
    tick();
    check("clr_snap_data", 64'(snap_data_out), 64'(packc(3, 4, 2, 0)));
    check("clr_count", 64'(count_out), 64'(0));
    snap_in = 1'b0; clear_in = 1'b0; evt_in = '0; snap_ready_in = 1'b1;
    tick();
    snap_ready_in = 1'b0;

    // Asynchronous reset mid-count with a held snapshot
    evt_in = 4'b1111; dir_in = 4'b1111; snap_in = 1'b1;
    tick();
    snap_in = 1'b0;
    tick();
    #2;
    rst_n_in = 1'b0;
    #1;
    model_reset();
    check("async_rst_count", 64'(count_out), 64'(0));
    check("async_rst_all", 64'({snap_valid_out, snap_drop_out, snap_wrap_out, snap_data_out, wrap_out}), 64'(0));
    @(posedge clk_in);
    #2;
    rst_n_in = 1'b1;
    tick();
    check("resume_count", 64'(count_out), 64'(packc(1, 1, 1, 1)));
    evt_in = '0;
    tick();

    // Random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      evt_in        = NCH'($urandom);
      dir_in        = NCH'($urandom);
      snap_in       = ($urandom_range(0, 3) == 0);
      snap_ready_in = ($urandom_range(0, 1) == 1);
      clear_in      = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) edge_mode_in = ~edge_mode_in;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_evt_counter.md
Name: multi_evt_counter

Overview:
- Parametrised multi-channel successor to the single-channel modulo event counter.
- NUM_CH independent modulo-MAX_COUNT counters, each with:
  - per-channel up/down direction
  - global level/edge qualification mode
  - a single-cycle wrap pulse
- A snapshot path captures all counters plus sticky wrap flags atomically and holds them behind a valid/ready handshake for the downstream readout/UART logic.

Parameters:
- NUM_CH, 4, number of independent counter channels (>=1).
- MAX_COUNT, 40_000, modulus; each count runs 0..MAX_COUNT-1 (>=2).
- CW (localparam), $clog2(MAX_COUNT), per-channel count width; not overridable.

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- rst_n_in  input  1  asynchronous, active-low reset.
- clear_in  input  1  synchronous clear of all counts and sticky flags.
- edge_mode_in  input  1  0: count every cycle evt is high; 1: count rising edges only.
- evt_in  input  NUM_CH  per-channel event inputs, already synchronous to clk_in.
- dir_in  input  NUM_CH  per-channel direction, 1 = up, 0 = down.
- count_out  output  NUM_CH*CW  live counts, channel i at [i*CW +: CW].
- wrap_out  output  NUM_CH  one-cycle pulse per channel on wrap.
- snap_in  input  1  snapshot request pulse.
- snap_valid_out  output  1  snapshot held and valid.
- snap_ready_in  input  1  consumer accepts snapshot.
- snap_data_out  output  NUM_CH*CW  captured counts, same packing as count_out.
- snap_wrap_out  output  NUM_CH  captured sticky wrap flags.
- snap_drop_out  output  1  one-cycle pulse when a snap_in request is discarded.

Behaviour:
- Reset: asserting rst_n_in low immediately forces all of the following to 0, mid-operation included:
  - count_out, wrap_out
  - per-channel edge history (prev)
  - sticky flags
  - snap_valid_out, snap_data_out, snap_wrap_out, snap_drop_out
- Qualification, per channel i:
  - qual[i] = evt_in[i] when edge_mode_in = 0.
  - qual[i] = evt_in[i] & ~prev[i] when edge_mode_in = 1.
  - prev[i] <= evt_in[i] every cycle, in both modes and during clear_in.
  - Switching mode mid-run creates no spurious count beyond this rule.
- Counting, per channel, registered with 1-cycle latency (qual at cycle t -> new count_out visible after edge t+1):
  - Up: MAX_COUNT-1 -> 0 with wrap_out[i] = 1 for that cycle; otherwise +1.
  - Down: 0 -> MAX_COUNT-1 with wrap_out[i] = 1; otherwise -1.
  - No qual: hold value; wrap_out[i] = 0.
  - Arithmetic is CW bits wide; count never leaves 0..MAX_COUNT-1.
- clear_in has priority over counting:
  - next counts = 0, wrap_out = 0, sticky = 0.
  - Events in that cycle are lost.
- Sticky flags: sticky[i] sets on wrap_out[i].
- Snapshot register. A capture occurs when snap_in = 1 and (snap_valid_out = 0 or snap_ready_in = 1).
  - snap_data_out <= current count_out (pre-update values of that cycle).
  - snap_wrap_out <= current sticky.
  - snap_valid_out <= 1.
  - sticky <= wrap pulses of the capture cycle only, so a wrap in the capture cycle belongs to the next window.
  - Capture together with clear_in: captures pre-clear values; clear then applies.
- Handshake:
  - snap_valid_out stays 1 with data stable until snap_valid_out & snap_ready_in.
  - On that cycle, without a new capture, snap_valid_out <= 0.
  - Back-to-back accept plus capture in one cycle keeps snap_valid_out = 1 with new data.
  - snap_in while valid and not ready: request discarded, snap_drop_out = 1 for one cycle, held data unchanged.
- snap_ready_in while snap_valid_out = 0 has no effect.

Test Plan:
- Reset release, MAX_COUNT=5, ch0 up, evt_in[0] high 7 cycles, level mode -> count_out ch0 sequence 1,2,3,4,0,1,2; wrap_out[0] pulses exactly on the 4->0 transition.
- ch1 down from 0, one level event -> ch1 = 4 (MAX_COUNT-1), wrap_out[1] pulse; sticky captured by a later snap gives snap_wrap_out[1] = 1, and the next snapshot gives 0.
- edge_mode_in = 1, evt_in[2] held high 10 cycles, then low, then high -> ch2 increments exactly twice.
- snap_in with snap_ready_in = 0 held, then a second snap_in -> snap_valid_out = 1, first data retained, snap_drop_out pulses once; ready = 1 -> valid drops next cycle.
- snap_in, clear_in and an up event on ch0 in the same cycle, ch0 = 3 -> snap_data_out ch0 = 3; count_out ch0 = 0 afterwards.
- Drive rst_n_in low asynchronously mid-count with snap_valid_out = 1 -> all outputs 0 before the next clock edge; counting resumes from 0 after release.
